ieee754_addsub: RTL and testbench
=================================

// Module: ieee754_addsub
//
// PURPOSE
//  Pipelined IEEE-754 binary32 adder. Computes y = a + b, correctly rounded.
//  Subtraction is a + (-b): the caller flips bit 31 of b.
//  Fully pipelined datapath block for single-precision kernels.
//  Accepts a new operand pair every cycle; no handshake.
//
// PARAMETERS
//  none -- format fixed at binary32, latency fixed at 3 register ranks
//
// PORTS
//  clock   in   1   rising-edge clock
//  resetn  in   1   reset, synchronous, active-low
//  a       in  32   operand A, binary32 bit pattern
//  b       in  32   operand B, binary32 bit pattern
//  y       out 32   sum a+b, binary32 bit pattern, registered
//
// BEHAVIOUR
//  - Reset: resetn=0 sampled at a rising edge clears all pipeline registers.
//    y = 32'h0000_0000 from that edge until real results drain out.
//  - Latency: three register ranks (stage 1 at capture edge k, stage 2 at
//    k+1, y at k+2).
//    The result for the operands captured at edge k is on y right after k+2.
//  - Throughput: 1 result/cycle. Back-to-back operands never interact.
//  - Stage 1 (align):
//    - unpack fields; hidden bit = 1 for exp!=0
//    - swap so |big| >= |small|
//    - right-shift the small significand by the exponent difference,
//      keeping guard, round and sticky bits; shifts >= 27 leave only sticky
//  - Stage 2 (add/normalise):
//    - add the significands on equal signs, else subtract small from big
//    - on carry-out, shift right 1 and exp+1 (fold the dropped bit into sticky)
//    - otherwise shift left by the leading-zero count, exp-lzc
//  - Stage 3 (round/pack): round-to-nearest-even on G/R/S.
//    A mantissa carry from rounding increments the exponent.
//  - Result sign = sign of larger-magnitude operand.
//    An exact zero sum from opposite signs gives +0; (-0)+(-0) = -0.
//  - Subnormals: inputs with exp=0 are treated as signed zero (FTZ/DAZ).
//    Results below 2^-126 are flushed to signed zero.
//  - Overflow: exponent >= 255 after rounding -> signed infinity 0x7F80_0000 / 0xFF80_0000.
//  - Specials:
//    - any NaN input -> canonical qNaN 32'h7FC0_0000
//    - +Inf + -Inf -> 32'h7FC0_0000
//    - Inf + finite -> that Inf
//  - Bit-exact vs. IEEE RNE for all normal in/out cases (0 ulp error).
//  - Reset asserted mid-stream:
//    - in-flight results are discarded
//    - y stays 0 until the first operand pair captured after release has passed all 3 ranks
//
// STRUCTURE
//  - Package ieee754_pkg holds:
//    - typedef struct packed {logic sign; logic [7:0] exp; logic [22:0] man;} fp32_t
//    - EXP_BIAS=127, EXP_MAX=8'hFF, QNAN=32'h7FC0_0000
//    - stage-register structs
//  - Sub-module ieee754_lzc: 28-bit leading-zero counter (combinational) used in stage 2.
//  - Top holds the three pipeline ranks and the special-case path.
//
// TESTING
//  - 0x3F800000 (1.0) + 0x40000000 (2.0) -> y=0x40400000 (3.0) after 3 edges.
//  - 0x3FC00000 (1.5) + 0xBFC00000 (-1.5) -> 0x00000000 (+0).
//  - Rounding:
//    - 0x3F800000 + 0x33800000 (2^-24, exact tie) -> 0x3F800000 (ties to even)
//    - 0x3F800000 + 0x33800001 -> 0x3F800001 (round up)
//  - Specials:
//    - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000
//    - 0x7F800000 + 0xFF800000 -> 0x7FC00000
//    - 0x00400000 (subnormal) + 0x00000000 -> 0x00000000
//  - Random stream, new operands every cycle, normal dist mean 0 sigma 100
//    (18 fractional bits): y must equal shortreal(a+b) bit-exact, 3 edges later.
//  - Reset mid-stream: resetn=0 for 2 cycles -> y=0 from first reset edge.
//    After release, first valid sum appears exactly 3 edges after first capture.

Source files
------------

// File: rtl/ieee754_pkg.sv
// Shared types and constants for the binary32 add/sub pipeline.
package ieee754_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // 24-bit significand plus guard/round/sticky
  localparam int unsigned SIG_W = 27;
  // significand sum with carry-out
  localparam int unsigned SUM_W = 28;
  // signed working exponent, wide enough for underflow/overflow detection
  localparam int unsigned EXPI_W = 10;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  // Aligned operands after stage 1.
  typedef struct packed {
    logic             special;
    logic [31:0]      special_val;
    logic             sign;
    logic             eff_sub;
    logic [7:0]       exp;
    logic [SIG_W-1:0] sig_big;
    logic [SIG_W-1:0] sig_small;
  } s1_t;

  // Normalised sum after stage 2; man excludes the leading one.
  typedef struct packed {
    logic              special;
    logic [31:0]       special_val;
    logic              sign;
    logic              zero;
    logic [EXPI_W-1:0] exp;
    logic [SIG_W-2:0]  man;
  } s2_t;

endpackage

// File: rtl/ieee754_lzc.sv
// Leading-zero counter for the 28-bit significand sum; all-zero input returns 28.
module ieee754_lzc
  import ieee754_pkg::*;
(
  input  logic [SUM_W-1:0] i_val,
  output logic [4:0]       o_cnt
);

  // Highest set bit wins since later iterations overwrite earlier ones.
  always_comb begin
    o_cnt = 5'(SUM_W);
    for (int i = 0; i < int'(SUM_W); i++) begin
      if (i_val[i]) o_cnt = 5'(int'(SUM_W) - 1 - i);
    end
  end

endmodule

// File: rtl/ieee754_addsub.sv
// Three-rank pipelined binary32 adder, round-to-nearest-even, FTZ/DAZ.
module ieee754_addsub
  import ieee754_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  fp32_t w_a, w_b, w_big, w_small;
  logic [30:0]       w_mag_a, w_mag_b;
  logic              w_swap, w_nan_a, w_nan_b, w_inf_a, w_inf_b;
  logic [23:0]       w_sig_big, w_sig_small;
  logic [7:0]        w_diff;
  logic [SIG_W-1:0]  w_sh_in, w_mask, w_small_al;
  s1_t               w_s1, r_s1;

  logic [SUM_W-1:0]  w_sum;
  logic [4:0]        w_lzc, w_shift;
  s2_t               w_s2, r_s2;

  logic              w_round_up, w_carry;
  logic [23:0]       w_frac_sum;
  logic [EXPI_W-1:0] w_exp_r;
  logic [31:0]       w_y, r_y;

  assign w_a = a;
  assign w_b = b;

  // Operand classification; subnormals read as zero magnitude.
  assign w_nan_a = (w_a.exp == EXP_MAX) && (w_a.man != 23'd0);
  assign w_nan_b = (w_b.exp == EXP_MAX) && (w_b.man != 23'd0);
  assign w_inf_a = (w_a.exp == EXP_MAX) && (w_a.man == 23'd0);
  assign w_inf_b = (w_b.exp == EXP_MAX) && (w_b.man == 23'd0);
  assign w_mag_a = (w_a.exp == 8'd0) ? 31'd0 : {w_a.exp, w_a.man};
  assign w_mag_b = (w_b.exp == 8'd0) ? 31'd0 : {w_b.exp, w_b.man};
  assign w_swap  = (w_mag_b > w_mag_a);
  assign w_big   = w_swap ? w_b : w_a;
  assign w_small = w_swap ? w_a : w_b;
  assign w_sig_big   = (w_big.exp == 8'd0)   ? 24'd0 : {1'b1, w_big.man};
  assign w_sig_small = (w_small.exp == 8'd0) ? 24'd0 : {1'b1, w_small.man};
  assign w_diff      = w_big.exp - w_small.exp;
  assign w_sh_in     = {w_sig_small, 3'b000};
  assign w_mask      = (27'd1 << w_diff[4:0]) - 27'd1;

  // Stage 1: align the smaller significand and resolve special operands.
  always_comb begin
    w_small_al = '0;
    w_s1       = '0;
    if (w_diff >= 8'(SIG_W)) begin
      w_small_al = {26'd0, |w_sig_small};
    end else begin
      w_small_al    = w_sh_in >> w_diff[4:0];
      w_small_al[0] = w_small_al[0] | (|(w_sh_in & w_mask));
    end
    w_s1.sign      = w_big.sign;
    w_s1.eff_sub   = w_a.sign ^ w_b.sign;
    w_s1.exp       = w_big.exp;
    w_s1.sig_big   = {w_sig_big, 3'b000};
    w_s1.sig_small = w_small_al;
    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_a.sign != w_b.sign))) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = QNAN;
    end else if (w_inf_a) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = {w_a.sign, EXP_MAX, 23'd0};
    end else if (w_inf_b) begin
      w_s1.special     = 1'b1;
      w_s1.special_val = {w_b.sign, EXP_MAX, 23'd0};
    end
  end

  assign w_sum = r_s1.eff_sub ? ({1'b0, r_s1.sig_big} - {1'b0, r_s1.sig_small})
                              : ({1'b0, r_s1.sig_big} + {1'b0, r_s1.sig_small});

  ieee754_lzc u_lzc (
    .i_val (w_sum),
    .o_cnt (w_lzc)
  );

  assign w_shift = w_lzc - 5'd1;

  // Stage 2: add/subtract and normalise so the leading one sits just above man.
  always_comb begin
    w_s2             = '0;
    w_s2.special     = r_s1.special;
    w_s2.special_val = r_s1.special_val;
    w_s2.zero        = (w_sum == '0);
    w_s2.sign        = (w_sum == '0) ? (r_s1.sign & ~r_s1.eff_sub) : r_s1.sign;
    if (w_sum[SUM_W-1]) begin
      w_s2.man = {w_sum[SUM_W-2:2], w_sum[1] | w_sum[0]};
      w_s2.exp = {2'b00, r_s1.exp} + 10'd1;
    end else begin
      w_s2.man = 26'(w_sum << w_shift);
      w_s2.exp = {2'b00, r_s1.exp} - {5'd0, w_shift};
    end
  end

  assign w_round_up = r_s2.man[2] & (r_s2.man[1] | r_s2.man[0] | r_s2.man[3]);
  assign w_frac_sum = {1'b0, r_s2.man[25:3]} + 24'(w_round_up);
  assign w_carry    = w_frac_sum[23];
  assign w_exp_r    = r_s2.exp + 10'(w_carry);

  // Stage 3: round to nearest even, then flush, saturate or pack.
  always_comb begin
    w_y = {r_s2.sign, w_exp_r[7:0], w_frac_sum[22:0]};
    if (r_s2.special) begin
      w_y = r_s2.special_val;
    end else if (r_s2.zero || w_exp_r[EXPI_W-1] || (w_exp_r == 10'd0)) begin
      w_y = {r_s2.sign, 31'd0};
    end else if (w_exp_r >= 10'(EXP_MAX)) begin
      w_y = {r_s2.sign, EXP_MAX, 23'd0};
    end
  end

  // Pipeline ranks with synchronous clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_y  <= '0;
    end else begin
      r_s1 <= w_s1;
      r_s2 <= w_s2;
      r_y  <= w_y;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_ieee754_addsub.sv
// Scoreboard bench: stimulus queues expected results, monitor compares on due cycle.
module tb_ieee754_addsub;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] y;

  ieee754_addsub dut (
    .clock  (clock),
    .resetn (resetn),
    .a      (a),
    .b      (b),
    .y      (y)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] exp_y;
    int          due;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compare every expectation that falls due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_tests++;
        if (e.due != cyc || y !== e.exp_y) begin
          n_fail++;
          $display("FAIL %s: y=%08h expected %08h (due cycle %0d, now %0d)",
                   e.tag, y, e.exp_y, e.due, cyc);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] ey, input int due, input string tag);
    exp_t e;
    e.exp_y = ey;
    e.due   = due;
    e.tag   = tag;
    q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ey, input string tag);
    a = ia;
    b = ib;
    push_exp(ey, cyc + 3, tag);
    @(posedge clock);
    #2;
  endtask

  // Drop in-flight expectations, hold reset, expect zeros until fresh data drains.
  task automatic do_reset(input int ncyc);
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    resetn = 1'b0;
    a = '0;
    b = '0;
    for (int i = 1; i <= ncyc + 2; i++) push_exp(32'h0, cyc + i, "reset_zero");
    repeat (ncyc) begin
      @(posedge clock);
      #2;
    end
    resetn = 1'b1;
  endtask

  // Reference: integer in units of 2^-18 to binary32 with round-to-nearest-even.
  function automatic logic [31:0] int_to_fp(input longint v);
    logic              s;
    longint unsigned   m, keep, rem, half;
    int                p, sh;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? longint'(-v) : longint'(v);
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    if (p <= 23) begin
      keep = m << (23 - p);
    end else begin
      sh   = p - 23;
      keep = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin
        keep = keep >> 1;
        p    = p + 1;
      end
    end
    return {s, 8'(p + 109), keep[22:0]};
  endfunction

  // Reference: binary32 (multiple of 2^-18) back to integer units of 2^-18.
  function automatic longint fp_to_int(input logic [31:0] f);
    longint mag;
    int     sh;
    if (f[30:23] == 8'd0) return 0;
    mag = longint'({1'b1, f[22:0]});
    sh  = int'(f[30:23]) - 132;
    if (sh >= 0) mag = mag << sh;
    else         mag = mag >> (-sh);
    return f[31] ? -mag : mag;
  endfunction

  function automatic longint rnd_norm();
    longint s = 0;
    for (int i = 0; i < 4; i++) s += longint'($urandom_range(45400000, 0)) - 22700000;
    return s;
  endfunction

  localparam int ND = 16;
  logic [31:0] dir_a [ND] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000,
                              32'h7F7FFFFF, 32'h7F800000, 32'h00400000, 32'h7F800001,
                              32'hFF800000, 32'h80000000, 32'h00000000, 32'h40400000,
                              32'h3F800000, 32'h00800000, 32'h7F7FFFFF, 32'h3FFFFFFF};
  logic [31:0] dir_b [ND] = '{32'h40000000, 32'hBFC00000, 32'h33800000, 32'h33800001,
                              32'h7F7FFFFF, 32'hFF800000, 32'h00000000, 32'h3F800000,
                              32'h3F800000, 32'h80000000, 32'h80000000, 32'hBF800000,
                              32'hBF7FFFFF, 32'h80800001, 32'h3F800000, 32'h3FFFFFFF};
  logic [31:0] dir_y [ND] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h3F800001,
                              32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7FC00000,
                              32'hFF800000, 32'h80000000, 32'h00000000, 32'h40000000,
                              32'h33800000, 32'h80000000, 32'h7F7FFFFF, 32'h407FFFFF};

  initial begin
    logic [31:0] fa, fb, fy;
    int          guard;
    do_reset(3);

    for (int i = 0; i < ND; i++) drive(dir_a[i], dir_b[i], dir_y[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 200; i++) begin
      if (i == 100) do_reset(2);
      fa = int_to_fp(rnd_norm());
      fb = (i % 25 == 7) ? {~fa[31], fa[30:0]} : int_to_fp(rnd_norm());
      fy = int_to_fp(fp_to_int(fa) + fp_to_int(fb));
      drive(fa, fb, fy, $sformatf("rand%0d", i));
    end

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clock);
      #3;
      guard++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
